// File: rtl/spi_reg_bridge_pkg.sv
// rtl/spi_reg_bridge_pkg.sv - shared types and constants for the SPI register bridge
package spi_bridge_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// rtl/spi_reg_bridge_if.sv - register bus between the SPI bridge and the sprite/palette register file
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/spi_reg_bridge_sync.sv
// rtl/spi_reg_bridge_sync.sv - multi-stage input synchroniser, with optional edge detection
module spi_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], din};
    end
  end

  assign q = ff[STAGES-1];

endmodule

module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic prev;

  spi_sync_bit #(
    .STAGES  (STAGES),
    .RST_VAL (RST_VAL)
  ) u_bit (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .q       (q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= RST_VAL;
    end else begin
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave to register bus bridge with burst write and prefetching read
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  input  logic             spi_cs,
  output logic             spi_miso,
  output logic             busy,
  spi_reg_bridge_if.master reg_bus
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q;

  state_t state, state_nx;

  logic [2:0]        bit_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [ADDR_W-1:0] addr;
  logic              we_r;
  logic              re_r;
  logic              load_r;
  logic              miso_r;

  logic       byte_end;
  logic       word_end;
  logic       cmd_done;
  logic       cmd_read;
  logic [7:0] cmd_byte;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_cs),
    .q       (cs_q),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_sclk),
    .q       (sclk_q),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_mosi),
    .q       (mosi_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A frame only opens with sclk at its idle-low level, so a mode mismatch cannot start mid-clock.
  always_comb begin
    state_nx = state;
    if (cs_q) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (!sclk_q) state_nx = CMD;
        CMD:     if (cmd_done) state_nx = cmd_read ? READ : WRITE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    byte_end = sclk_rise && (bit_cnt == 3'd7);
    word_end = byte_end && (byte_cnt == LAST_BYTE);
    cmd_done = (state == CMD) && byte_end;
    cmd_byte = {rx_sh[6:0], mosi_q};
    cmd_read = rx_sh[CMD_RW_BIT-1];
    spi_miso = (state == READ) && miso_r;
    busy     = ~cs_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      addr     <= '0;
      we_r     <= 1'b0;
      re_r     <= 1'b0;
      load_r   <= 1'b0;
      miso_r   <= 1'b0;
    end else begin
      we_r   <= 1'b0;
      re_r   <= 1'b0;
      load_r <= re_r;
      if (cs_rise || cs_fall || state == IDLE) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        tx_sh    <= '0;
        miso_r   <= 1'b0;
        load_r   <= 1'b0;
      end else begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (state != READ) rx_sh <= {rx_sh[DATA_W-2:0], mosi_q};
          if (byte_end && state != CMD) byte_cnt <= word_end ? '0 : byte_cnt + 1'b1;
        end
        if (cmd_done) begin
          addr <= cmd_byte[ADDR_W-1:0];
          re_r <= cmd_read;
        end
        if (state == WRITE && word_end) we_r <= 1'b1;
        // Prefetch the next word as soon as the current one is fully clocked in.
        if (state == READ && word_end) re_r <= 1'b1;
        if (we_r) addr <= addr + 1'b1;
        if (load_r) begin
          tx_sh <= reg_bus.reg_rdata;
          addr  <= addr + 1'b1;
        end else if (state == READ && sclk_fall) begin
          miso_r <= tx_sh[DATA_W-1];
          tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign reg_bus.reg_addr  = addr;
  assign reg_bus.reg_wdata = rx_sh;
  assign reg_bus.reg_we    = we_r;
  assign reg_bus.reg_re    = re_r;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - scoreboard bench for spi_reg_bridge with 8- and 16-bit word instances
module tb_spi_reg_bridge;

  localparam int H = 6;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sclk    = 1'b0;
  logic mosi    = 1'b0;
  logic cs8     = 1'b1;
  logic cs16    = 1'b1;
  logic miso8, miso16, busy8, busy16;

  always #5 clk = ~clk;

  spi_reg_bridge_if #(.ADDR_W(7), .DATA_W(8))  bus8 ();
  spi_reg_bridge_if #(.ADDR_W(7), .DATA_W(16)) bus16 ();

  spi_reg_bridge #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs(cs8),
    .spi_miso(miso8), .busy(busy8), .reg_bus(bus8)
  );

  spi_reg_bridge #(.ADDR_W(7), .DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs(cs16),
    .spi_miso(miso16), .busy(busy16), .reg_bus(bus16)
  );

  logic [7:0]  mem8  [128] = '{default: 8'h00};
  logic [15:0] mem16 [128] = '{default: 16'h0000};

  always @(posedge clk) begin
    if (bus8.reg_re) bus8.reg_rdata <= mem8[bus8.reg_addr];
    if (bus8.reg_we) mem8[bus8.reg_addr] = bus8.reg_wdata;
  end

  always @(posedge clk) begin
    if (bus16.reg_re) bus16.reg_rdata <= mem16[bus16.reg_addr];
    if (bus16.reg_we) mem16[bus16.reg_addr] = bus16.reg_wdata;
  end

  typedef struct packed {
    logic        rd;
    logic [6:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t        q8[$];
  ev_t        q16[$];
  logic [7:0] tx_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int qsize(input int which);
    return (which == 0) ? q8.size() : q16.size();
  endfunction

  task automatic check_strobe(input int which, input logic we, input logic re,
                              input logic [6:0] a, input logic [15:0] d);
    ev_t e;
    int  n;
    n = qsize(which);
    check("strobe_exclusive", {31'b0, we & re}, 32'd0);
    check("strobe_expected", {31'b0, n > 0}, 32'd1);
    if (n > 0) begin
      e = (which == 0) ? q8.pop_front() : q16.pop_front();
      check("strobe_kind", {31'b0, re}, {31'b0, e.rd});
      check("strobe_addr", {25'b0, a}, {25'b0, e.addr});
      if (!e.rd) check("strobe_wdata", {16'b0, d}, {16'b0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (bus8.reg_we || bus8.reg_re))
      check_strobe(0, bus8.reg_we, bus8.reg_re, bus8.reg_addr, {8'h00, bus8.reg_wdata});
    if (reset_n && (bus16.reg_we || bus16.reg_re))
      check_strobe(1, bus16.reg_we, bus16.reg_re, bus16.reg_addr, bus16.reg_wdata);
  end

  // Frame-level reference: whole words written at consecutive (wrapping) addresses,
  // and for reads one fetch per completed word plus one lookahead fetch.
  task automatic model_frame(input int which, input logic [7:0] cmd, input int nbytes);
    int   bpw;
    int   nwords;
    ev_t  e;
    bpw    = (which == 0) ? 1 : 2;
    nwords = nbytes / bpw;
    if (!cmd[7]) begin
      for (int k = 0; k < nwords; k++) begin
        e.rd   = 1'b0;
        e.addr = cmd[6:0] + 7'(k);
        e.data = (which == 0) ? {8'h00, tx_q[k]} : {tx_q[2*k], tx_q[2*k+1]};
        if (which == 0) q8.push_back(e); else q16.push_back(e);
      end
    end else begin
      for (int k = 0; k <= nwords; k++) begin
        e.rd   = 1'b1;
        e.addr = cmd[6:0] + 7'(k);
        e.data = 16'h0000;
        if (which == 0) q8.push_back(e); else q16.push_back(e);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_cs(input int which, input logic v);
    if (which == 0) cs8 = v; else cs16 = v;
  endtask

  task automatic spi_xfer(input int which, input logic [7:0] cmd, input int nbytes,
                          input int partial, input bit raise_cs);
    logic [7:0]  exp_rx[$];
    logic [7:0]  rx_byte;
    logic [7:0]  b;
    logic [6:0]  a;
    logic [15:0] w;
    logic        bitv;
    logic        miso_or;
    int          nbits;
    int          nrx;
    exp_rx  = {};
    rx_byte = 8'h00;
    miso_or = 1'b0;
    nrx     = 0;
    while (tx_q.size() < nbytes + 1) tx_q.push_back(8'($urandom));
    model_frame(which, cmd, nbytes);
    for (int j = 0; j < nbytes; j++) begin
      a = cmd[6:0] + 7'((which == 0) ? j : j / 2);
      if (which == 0) exp_rx.push_back(mem8[a]);
      else begin
        w = mem16[a];
        exp_rx.push_back((j % 2 == 0) ? w[15:8] : w[7:0]);
      end
    end
    set_cs(which, 1'b0);
    tick(H);
    nbits = 8 + 8 * nbytes + partial;
    for (int i = 0; i < nbits; i++) begin
      b    = (i < 8) ? cmd : tx_q[(i - 8) / 8];
      mosi = b[7 - (i % 8)];
      tick(H);
      sclk    = 1'b1;
      bitv    = (which == 0) ? miso8 : miso16;
      miso_or = miso_or | bitv;
      if (i >= 8) begin
        rx_byte = {rx_byte[6:0], bitv};
        if ((i - 8) % 8 == 7) begin
          if (cmd[7]) check("miso_byte", {24'b0, rx_byte}, {24'b0, exp_rx[nrx]});
          nrx++;
        end
      end
      tick(H);
      sclk = 1'b0;
    end
    tick(H);
    if (!cmd[7]) check("miso_zero_in_write", {31'b0, miso_or}, 32'd0);
    tx_q = {};
    if (raise_cs) begin
      set_cs(which, 1'b1);
      tick(4 * H);
      check("strobe_count", qsize(which), 32'd0);
    end
  endtask

  initial begin
    tick(4);
    check("rst_addr",  {25'b0, bus8.reg_addr}, 32'd0);
    check("rst_wdata", {24'b0, bus8.reg_wdata}, 32'd0);
    check("rst_we",    {31'b0, bus8.reg_we}, 32'd0);
    check("rst_re",    {31'b0, bus8.reg_re}, 32'd0);
    check("rst_miso",  {31'b0, miso8}, 32'd0);
    check("rst_busy",  {31'b0, busy8}, 32'd0);
    check("rst_busy16", {31'b0, busy16}, 32'd0);
    reset_n = 1'b1;
    tick(4);

    cs8 = 1'b0;
    tick(2 * H);
    check("busy_cs_low", {31'b0, busy8}, 32'd1);
    cs8 = 1'b1;
    tick(2 * H);
    check("busy_cs_high", {31'b0, busy8}, 32'd0);
    check("no_edge_strobes", qsize(0), 32'd0);

    tx_q = '{8'hA1, 8'hB2};
    spi_xfer(0, 8'h05, 2, 0, 1);
    tx_q = '{8'h3C, 8'hC3};
    spi_xfer(0, 8'h05, 2, 0, 1);
    spi_xfer(0, 8'h85, 2, 0, 1);
    tx_q = '{8'h11, 8'h22};
    spi_xfer(0, 8'h7F, 2, 0, 1);
    spi_xfer(0, 8'hFF, 1, 0, 1);

    tx_q = '{8'hBE, 8'hEF};
    spi_xfer(1, 8'h02, 2, 0, 1);
    spi_xfer(1, 8'h82, 2, 0, 1);

    spi_xfer(0, 8'h10, 0, 5, 0);
    check("abort_busy_before", {31'b0, busy8}, 32'd1);
    cs8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_low", {31'b0, busy8}, 32'd0);
    check("abort_miso_low", {31'b0, miso8}, 32'd0);
    tick(4 * H);
    check("abort_no_we", qsize(0), 32'd0);
    tx_q = '{8'h5A};
    spi_xfer(0, 8'h10, 1, 0, 1);

    spi_xfer(0, 8'h85, 0, 3, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr",  {25'b0, bus8.reg_addr}, 32'd0);
    check("mid_rst_wdata", {24'b0, bus8.reg_wdata}, 32'd0);
    check("mid_rst_we",    {31'b0, bus8.reg_we}, 32'd0);
    check("mid_rst_re",    {31'b0, bus8.reg_re}, 32'd0);
    check("mid_rst_miso",  {31'b0, miso8}, 32'd0);
    check("mid_rst_busy",  {31'b0, busy8}, 32'd0);
    check("mid_rst_pending", qsize(0), 32'd0);
    cs8 = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    tx_q = '{8'h55};
    spi_xfer(0, 8'h01, 1, 0, 1);

    for (int f = 0; f < 30; f++) begin
      logic [7:0] c;
      int nb;
      int pa;
      c  = 8'($urandom);
      nb = $urandom_range(0, 4);
      pa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      spi_xfer(0, c, nb, pa, 1);
    end
    for (int f = 0; f < 8; f++) begin
      logic [7:0] c;
      int nb;
      c  = 8'($urandom);
      nb = $urandom_range(0, 4);
      spi_xfer(1, c, nb, 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
